// File: rtl/group_smear_pipe_pkg.sv
// -----------------------------------------------------------------------------
// samDefines: shared definitions for the SAM search-engine mask stages.
//   compare_t : one per-group COMPARE result, bit GT_BIT carries '>'
//   op_e      : mask update operation requested with each start
//   state_e   : group_smear_pipe sequencing states
// -----------------------------------------------------------------------------
package samDefines;

   localparam int CMP_W_DEF   = 3;
   localparam int GT_BIT      = 0;
   localparam int MAX_GPI_DEF = 4;

   typedef logic [CMP_W_DEF-1:0] compare_t;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_LOAD  = 2'd1,
      OP_OR    = 2'd2,
      OP_CLEAR = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SMEAR  = 2'd1,
      ST_ENCODE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/group_smear_pipe_prio_enc.sv
// -----------------------------------------------------------------------------
// grp_prio_enc: lowest-set-bit encoder over a group vector.
//   vec   in  GROUP_CNT  group vector
//   found out 1          vec is non-zero
//   idx   out IDX_W      index of lowest set bit, GROUP_CNT when vec is zero
// Purely combinational; also used by the shift engine.
// -----------------------------------------------------------------------------
module grp_prio_enc
   import samDefines::*;
#(
   parameter int GROUP_CNT = 32,
   parameter int IDX_W     = $clog2(GROUP_CNT + 1)
) (
   input  logic [GROUP_CNT-1:0] vec,
   output logic                 found,
   output logic [IDX_W-1:0]     idx
);

   always_comb begin
      found = |vec;
      idx   = IDX_W'(GROUP_CNT);
      // Scan downward so the lowest set bit is the last one written.
      for (int i = GROUP_CNT - 1; i >= 0; i--) begin
         if (vec[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/group_smear_pipe.sv
// -----------------------------------------------------------------------------
// group_smear_pipe: spreads each item's '>' result from the group holding the
// item's key to every group the item occupies, producing a grpMask that is
// dense from the insertion point onward, plus its lowest set index.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   start, ready    request handshake; start is taken only while ready=1
//   op              0=NOP 1=LOAD 2=OR 3=CLEAR
//   gpi             groups per item, legal 1..MAX_GPI
//   overTgt         group g sits over a key
//   grpRslt         (GROUP_CNT+1) packed COMPARE results, top one is a spare
//   stop            group g must never be selected
//   done, ack       result valid until acknowledged
//   err             last request carried an illegal gpi
//   grpMask, found, firstIdx   result; held between requests
//
// state  | meaning
// IDLE   | ready=1, waiting for start
// SMEAR  | build raw mask from captured inputs, apply op
// ENCODE | register found / firstIdx of the new mask
// DONE   | done=1, outputs frozen until ack
// -----------------------------------------------------------------------------
module group_smear_pipe
   import samDefines::*;
#(
   parameter int GROUP_CNT = 32,
   parameter int MAX_GPI   = MAX_GPI_DEF,
   parameter int CMP_W     = CMP_W_DEF,
   parameter int IDX_W     = $clog2(GROUP_CNT + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [1:0]                   op,
   input  logic [2:0]                   gpi,
   input  logic [GROUP_CNT-1:0]         overTgt,
   input  logic [(GROUP_CNT+1)*CMP_W-1:0] grpRslt,
   input  logic [GROUP_CNT-1:0]         stop,
   output logic                         ready,
   output logic                         done,
   input  logic                         ack,
   output logic                         err,
   output logic [GROUP_CNT-1:0]         grpMask,
   output logic                         found,
   output logic [IDX_W-1:0]             firstIdx
);

   state_e                        state_q, state_d;
   op_e                           op_q, op_d;
   logic [2:0]                    gpi_q, gpi_d;
   logic [GROUP_CNT-1:0]          over_tgt_q, over_tgt_d;
   logic [(GROUP_CNT+1)*CMP_W-1:0] grp_rslt_q, grp_rslt_d;
   logic [GROUP_CNT-1:0]          stop_q, stop_d;
   logic [GROUP_CNT-1:0]          grp_mask_q, grp_mask_d;
   logic                          found_q, found_d;
   logic [IDX_W-1:0]              first_idx_q, first_idx_d;
   logic                          err_q, err_d;
   logic                          done_q, done_d;
   logic                          ready_q, ready_d;

   logic [GROUP_CNT:0]            gt;
   logic [GROUP_CNT:0]            stop_x;
   logic [GROUP_CNT-1:0]          raw;
   logic                          gpi_legal;
   logic                          enc_found;
   logic [IDX_W-1:0]              enc_idx;
   logic                          unused_cmp_bits;

   // Only the gt bit of each COMPARE is consumed; the rest ride along.
   assign unused_cmp_bits = ^grp_rslt_q;

   always_comb begin
      gt = '0;
      for (int g = 0; g <= GROUP_CNT; g++) begin
         gt[g] = grp_rslt_q[g*CMP_W + GT_BIT];
      end
   end

   // The spare top location is always stopped, so an item running off the
   // end of the row never contributes.
   assign stop_x    = {1'b1, stop_q};
   assign gpi_legal = (gpi_q != 3'd0) && (int'(gpi_q) <= MAX_GPI);

   // One constant-division smear per legal gpi, selected by gpi_q; the loop
   // bounds are static so g/v folds to a constant in every unrolled slot.
   always_comb begin
      int k;
      raw = '0;
      k   = 0;
      for (int v = 1; v <= MAX_GPI; v++) begin
         if (int'(gpi_q) == v) begin
            for (int g = 0; g < GROUP_CNT; g++) begin
               k = (g / v) * v + v - 1;
               if (over_tgt_q[g]) begin
                  raw[g] = gt[g] & ~stop_x[g];
               end else if (k <= GROUP_CNT) begin
                  raw[g] = gt[k] & ~stop_x[k];
               end
            end
         end
      end
   end

   grp_prio_enc #(
      .GROUP_CNT (GROUP_CNT),
      .IDX_W     (IDX_W)
   ) u_prio_enc (
      .vec   (grp_mask_q),
      .found (enc_found),
      .idx   (enc_idx)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      gpi_d       = gpi_q;
      over_tgt_d  = over_tgt_q;
      grp_rslt_d  = grp_rslt_q;
      stop_d      = stop_q;
      grp_mask_d  = grp_mask_q;
      found_d     = found_q;
      first_idx_d = first_idx_q;
      err_d       = err_q;
      done_d      = done_q;
      ready_d     = ready_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start && ready_q) begin
               op_d       = op_e'(op);
               gpi_d      = gpi;
               over_tgt_d = overTgt;
               grp_rslt_d = grpRslt;
               stop_d     = stop;
               ready_d    = 1'b0;
               state_d    = ST_SMEAR;
            end
         end
         ST_SMEAR: begin
            if (gpi_legal) begin
               err_d = 1'b0;
               unique case (op_q)
                  OP_LOAD:  grp_mask_d = raw;
                  OP_OR:    grp_mask_d = grp_mask_q | raw;
                  OP_CLEAR: grp_mask_d = '0;
                  OP_NOP:   grp_mask_d = grp_mask_q;
               endcase
            end else begin
               err_d = 1'b1;
            end
            state_d = ST_ENCODE;
         end
         ST_ENCODE: begin
            found_d     = enc_found;
            first_idx_d = enc_idx;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            // done rises one cycle after entering DONE; ack counts only once
            // the consumer has been able to see it.
            if (done_q && ack) begin
               done_d  = 1'b0;
               ready_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               done_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_NOP;
         gpi_q       <= '0;
         over_tgt_q  <= '0;
         grp_rslt_q  <= '0;
         stop_q      <= '0;
         grp_mask_q  <= '0;
         found_q     <= 1'b0;
         first_idx_q <= IDX_W'(GROUP_CNT);
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         gpi_q       <= gpi_d;
         over_tgt_q  <= over_tgt_d;
         grp_rslt_q  <= grp_rslt_d;
         stop_q      <= stop_d;
         grp_mask_q  <= grp_mask_d;
         found_q     <= found_d;
         first_idx_q <= first_idx_d;
         err_q       <= err_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
      end
   end

   assign ready    = ready_q;
   assign done     = done_q;
   assign err      = err_q;
   assign grpMask  = grp_mask_q;
   assign found    = found_q;
   assign firstIdx = first_idx_q;

endmodule

// File: tb/tb_group_smear_pipe.sv
module tb_group_smear_pipe;
   import samDefines::*;

   localparam int GC = 8;
   localparam int MG = 4;
   localparam int CW = 3;
   localparam int IW = 4;

   logic                   clk = 1'b0;
   logic                   reset, start, ack;
   logic [1:0]             op;
   logic [2:0]             gpi;
   logic [GC-1:0]          overTgt, stop;
   logic [(GC+1)*CW-1:0]   grpRslt;
   logic                   ready, done, err, found;
   logic [GC-1:0]          grpMask;
   logic [IW-1:0]          firstIdx;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   group_smear_pipe #(.GROUP_CNT(GC), .MAX_GPI(MG), .CMP_W(CW), .IDX_W(IW)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .gpi(gpi),
      .overTgt(overTgt), .grpRslt(grpRslt), .stop(stop), .ready(ready),
      .done(done), .ack(ack), .err(err), .grpMask(grpMask), .found(found),
      .firstIdx(firstIdx)
   );

   typedef struct {
      string      name;
      logic [1:0] op;
      logic [2:0] gpi;
      logic [7:0] over;
      logic [8:0] gt;
      logic [7:0] stop;
      logic [7:0] exp_mask;
      logic       exp_found;
      logic [3:0] exp_idx;
      logic       exp_err;
   } vec_t;

   typedef struct {
      logic [7:0] mask;
      logic       found;
      logic [3:0] idx;
      logic       err;
   } exp_t;

   vec_t tbl[12];
   exp_t sb[$];

   function automatic vec_t mk(input string nm, input logic [1:0] o, input logic [2:0] g,
                               input logic [7:0] ov, input logic [8:0] gtv, input logic [7:0] st,
                               input logic [7:0] m, input logic f, input logic [3:0] ix,
                               input logic e);
      vec_t v;
      v.name = nm; v.op = o; v.gpi = g; v.over = ov; v.gt = gtv; v.stop = st;
      v.exp_mask = m; v.exp_found = f; v.exp_idx = ix; v.exp_err = e;
      return v;
   endfunction

   // Non-gt compare bits are driven high so any misuse of them shows up.
   function automatic logic [(GC+1)*CW-1:0] pack_rslt(input logic [8:0] gtv);
      logic [(GC+1)*CW-1:0] r;
      r = '1;
      for (int g = 0; g <= GC; g++) r[g*CW] = gtv[g];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_req(input vec_t v);
      exp_t e;
      int   lat;
      @(negedge clk);
      chk({v.name, " ready before start"}, 32'(ready), 32'd1);
      op = v.op; gpi = v.gpi; overTgt = v.over; stop = v.stop;
      grpRslt = pack_rslt(v.gt); start = 1'b1;
      e.mask = v.exp_mask; e.found = v.exp_found; e.idx = v.exp_idx; e.err = v.exp_err;
      sb.push_back(e);
      @(posedge clk); #1;
      // Scramble inputs after acceptance; the result must come from captured copies.
      start = 1'b0; op = ~v.op; gpi = ~v.gpi; overTgt = ~v.over; stop = ~v.stop;
      grpRslt = ~pack_rslt(v.gt);
      lat = 0;
      while (!done && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({v.name, " done latency"}, 32'(lat), 32'd3);
      e = sb.pop_front();
      chk({v.name, " grpMask"},  32'(grpMask),  32'(e.mask));
      chk({v.name, " found"},    32'(found),    32'(e.found));
      chk({v.name, " firstIdx"}, 32'(firstIdx), 32'(e.idx));
      chk({v.name, " err"},      32'(err),      32'(e.err));
      // A start during DONE must be dropped and done must hold.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk({v.name, " ready in done"}, 32'(ready), 32'd0);
      chk({v.name, " done held"},     32'(done),  32'd1);
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      chk({v.name, " done after ack"},  32'(done),    32'd0);
      chk({v.name, " ready after ack"}, 32'(ready),   32'd1);
      chk({v.name, " mask persists"},   32'(grpMask), 32'(e.mask));
   endtask

   initial begin
      // Even groups sit over their own key with gt=0; odd groups take gt[k].
      tbl[0]  = mk("gpi2_load",   2'd1, 3'd2, 8'h55, 9'h0A8, 8'h00, 8'hA8, 1'b1, 4'd3, 1'b0);
      tbl[1]  = mk("gpi3_load",   2'd1, 3'd3, 8'h00, 9'h120, 8'h00, 8'h38, 1'b1, 4'd3, 1'b0);
      tbl[2]  = mk("gpi3_stop5",  2'd1, 3'd3, 8'h00, 9'h120, 8'h20, 8'h00, 1'b0, 4'd8, 1'b0);
      tbl[3]  = mk("load_c0",     2'd1, 3'd2, 8'h00, 9'h080, 8'h00, 8'hC0, 1'b1, 4'd6, 1'b0);
      tbl[4]  = mk("or_0c",       2'd2, 3'd2, 8'h00, 9'h008, 8'h00, 8'hCC, 1'b1, 4'd2, 1'b0);
      tbl[5]  = mk("clear",       2'd3, 3'd2, 8'h00, 9'h1FF, 8'h00, 8'h00, 1'b0, 4'd8, 1'b0);
      tbl[6]  = mk("gpi4_load",   2'd1, 3'd4, 8'h00, 9'h080, 8'h00, 8'hF0, 1'b1, 4'd4, 1'b0);
      tbl[7]  = mk("gpi0_illeg",  2'd1, 3'd0, 8'hFF, 9'h1FF, 8'h00, 8'hF0, 1'b1, 4'd4, 1'b1);
      tbl[8]  = mk("gpi5_illeg",  2'd1, 3'd5, 8'h00, 9'h1FF, 8'h00, 8'hF0, 1'b1, 4'd4, 1'b1);
      tbl[9]  = mk("nop_gpi1",    2'd0, 3'd1, 8'h00, 9'h1FF, 8'h00, 8'hF0, 1'b1, 4'd4, 1'b0);
      tbl[10] = mk("gpi1_stop",   2'd1, 3'd1, 8'hFF, 9'h05A, 8'h02, 8'h58, 1'b1, 4'd3, 1'b0);
      tbl[11] = mk("gpi4_mixed",  2'd1, 3'd4, 8'h11, 9'h081, 8'h00, 8'hE1, 1'b1, 4'd0, 1'b0);

      reset = 1'b1; start = 1'b0; ack = 1'b0; op = '0; gpi = '0;
      overTgt = '0; stop = '0; grpRslt = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset ready",    32'(ready),    32'd1);
      chk("reset done",     32'(done),     32'd0);
      chk("reset err",      32'(err),      32'd0);
      chk("reset grpMask",  32'(grpMask),  32'd0);
      chk("reset found",    32'(found),    32'd0);
      chk("reset firstIdx", 32'(firstIdx), 32'd8);

      // ack while idle does nothing
      ack = 1'b1;
      @(posedge clk); #1 ack = 1'b0;
      chk("idle ack ready", 32'(ready), 32'd1);
      chk("idle ack done",  32'(done),  32'd0);

      for (int i = 0; i < 12; i++) run_req(tbl[i]);

      // Reset while in ENCODE drops the request.
      @(negedge clk);
      op = 2'd1; gpi = 3'd4; overTgt = '0; stop = '0; grpRslt = pack_rslt(9'h080);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      chk("in-flight ready low", 32'(ready), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      chk("mid reset ready",    32'(ready),    32'd1);
      chk("mid reset done",     32'(done),     32'd0);
      chk("mid reset grpMask",  32'(grpMask),  32'd0);
      chk("mid reset found",    32'(found),    32'd0);
      chk("mid reset firstIdx", 32'(firstIdx), 32'd8);
      repeat (3) @(posedge clk);
      #1 chk("dropped no done", 32'(done), 32'd0);

      run_req(mk("after_reset", 2'd1, 3'd1, 8'h00, 9'h001, 8'h00, 8'h01, 1'b1, 4'd0, 1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
